// File: rtl/texture_select_ctrl_if.sv
// Texture change request channel: valid/ready handshake carrying a 2-bit texture index.
interface texture_select_ctrl_if;
    logic       req_valid;
    logic [1:0] req_texture;
    logic       req_ready;

    modport master (
        output req_valid,
        output req_texture,
        input  req_ready
    );

    modport slave (
        input  req_valid,
        input  req_texture,
        output req_ready
    );
endinterface

// File: rtl/texture_select_ctrl.sv
// Tear-free texture select: request or auto-cycle changes are committed only at the start of vertical blanking.
// Optional feature macro TEXTURE_SEL_STEP_EN adds a 'step' strobe that requests the next texture.
module texture_select_ctrl #(
    parameter int H_ACTIVE    = 640,
    parameter int V_ACTIVE    = 480,
    parameter int AUTO_FRAMES = 60,
    parameter int DEFAULT_TEX = 0
) (
    input  logic                  vga_clk,
    input  logic                  reset,
    input  logic [9:0]            DrawX,
    input  logic [9:0]            DrawY,
    texture_select_ctrl_if.slave  req,
    input  logic                  auto_en,
`ifdef TEXTURE_SEL_STEP_EN
    input  logic                  step,
`endif
    output logic [1:0]            texture,
    output logic                  tex_changed,
    output logic                  frame_tick
);

    generate
        if (AUTO_FRAMES < 1 || AUTO_FRAMES > 1023 ||
            H_ACTIVE < 1 || H_ACTIVE > 1024 ||
            V_ACTIVE < 1 || V_ACTIVE > 1023) begin : g_bad_param
            $error("texture_select_ctrl: parameter out of range");
        end
    endgenerate

    localparam logic [1:0] DEF_TEX   = 2'(DEFAULT_TEX);
    localparam logic [9:0] AUTO_LAST = 10'(AUTO_FRAMES - 1);
    localparam logic [9:0] BLANK_Y   = 10'(V_ACTIVE);

    typedef enum logic {
        IDLE,
        PENDING
    } state_t;

    state_t     state;
    logic [1:0] pend;
    logic [9:0] frame_cnt;
    logic       cond;
    logic       cond_q;
    logic       fb;

    // A stalled DrawX would hold cond high for many cycles; only its first cycle is a boundary.
    assign cond = (DrawX == 10'd0) && (DrawY == BLANK_Y);
    assign fb   = cond && !cond_q;

`ifdef TEXTURE_SEL_STEP_EN
    logic step_q;
    logic step_edge;

    assign step_edge = step && !step_q;

    always_ff @(posedge vga_clk) begin
        if (reset) begin
            step_q <= 1'b0;
        end else begin
            step_q <= step;
        end
    end
`endif

    always_ff @(posedge vga_clk) begin
        if (reset) begin
            state         <= IDLE;
            texture       <= DEF_TEX;
            pend          <= 2'd0;
            frame_cnt     <= 10'd0;
            cond_q        <= 1'b0;
            req.req_ready <= 1'b1;
            tex_changed   <= 1'b0;
            frame_tick    <= 1'b0;
        end else begin
            cond_q      <= cond;
            frame_tick  <= fb;
            tex_changed <= 1'b0;

            if (!auto_en) begin
                frame_cnt <= 10'd0;
            end

            case (state)
                IDLE: begin
                    if (auto_en && fb) begin
                        if (frame_cnt == AUTO_LAST) begin
                            texture     <= texture + 2'd1;
                            tex_changed <= 1'b1;
                            frame_cnt   <= 10'd0;
                        end else begin
                            frame_cnt <= frame_cnt + 10'd1;
                        end
                    end

                    // A request taken on the fb cycle waits for the following boundary.
                    if (req.req_valid && req.req_ready) begin
                        pend          <= req.req_texture;
                        state         <= PENDING;
                        req.req_ready <= 1'b0;
                    end
`ifdef TEXTURE_SEL_STEP_EN
                    else if (step_edge) begin
                        pend          <= texture + 2'd1;
                        state         <= PENDING;
                        req.req_ready <= 1'b0;
                    end
`endif
                end

                PENDING: begin
                    if (fb) begin
                        texture       <= pend;
                        tex_changed   <= 1'b1;
                        frame_cnt     <= 10'd0;
                        state         <= IDLE;
                        req.req_ready <= 1'b1;
                    end
                end

                default: begin
                    state         <= IDLE;
                    req.req_ready <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_texture_select_ctrl.sv
// Directed bench for texture_select_ctrl using a compressed raster (a few mid-frame pixels then the blanking start).
module tb_texture_select_ctrl;

    logic       vga_clk = 1'b0;
    logic       reset;
    logic [9:0] DrawX;
    logic [9:0] DrawY;
    logic       auto_en;
    logic [1:0] texture;
    logic       tex_changed;
    logic       frame_tick;
`ifdef TEXTURE_SEL_STEP_EN
    logic       step;
`endif

    int vectors     = 0;
    int miscompares = 0;

    texture_select_ctrl_if req_if ();

    texture_select_ctrl #(
        .H_ACTIVE    (640),
        .V_ACTIVE    (480),
        .AUTO_FRAMES (2),
        .DEFAULT_TEX (0)
    ) dut (
        .vga_clk     (vga_clk),
        .reset       (reset),
        .DrawX       (DrawX),
        .DrawY       (DrawY),
        .req         (req_if),
        .auto_en     (auto_en),
`ifdef TEXTURE_SEL_STEP_EN
        .step        (step),
`endif
        .texture     (texture),
        .tex_changed (tex_changed),
        .frame_tick  (frame_tick)
    );

    always #5 vga_clk = ~vga_clk;

    task automatic tick();
        @(posedge vga_clk);
        #1;
    endtask

    task automatic mid_frame(input int n);
        DrawY = 10'd100;
        for (int i = 0; i < n; i++) begin
            DrawX = 10'(i + 5);
            tick();
        end
    endtask

    // Hold the blanking-start pixel for 'hold' cycles, then move on; report what followed the first edge.
    task automatic run_boundary(input int hold, output logic [1:0] tex0, output logic chg0,
                                output logic tick0, output int ticks, output int chgs);
        DrawX = 10'd0;
        DrawY = 10'd480;
        ticks = 0;
        chgs  = 0;
        tex0  = 2'd0;
        chg0  = 1'b0;
        tick0 = 1'b0;
        for (int i = 0; i < hold; i++) begin
            tick();
            if (i == 0) begin
                tex0  = texture;
                chg0  = tex_changed;
                tick0 = frame_tick;
            end
            ticks += int'(frame_tick);
            chgs  += int'(tex_changed);
        end
        DrawX = 10'd1;
        for (int i = 0; i < 2; i++) begin
            tick();
            ticks += int'(frame_tick);
            chgs  += int'(tex_changed);
        end
    endtask

    task automatic test_reset();
        logic [1:0] t0;
        logic       c0, k0;
        int         nt, nc;
        reset = 1'b1;
        DrawX = 10'd5;
        DrawY = 10'd100;
        repeat (3) tick();
        vectors++;
        if (texture !== 2'd0) begin
            miscompares++;
            $display("[TB] FAIL reset_texture: got %0d expected 0", texture);
        end
        vectors++;
        if (req_if.req_ready !== 1'b1) begin
            miscompares++;
            $display("[TB] FAIL reset_ready: got %b expected 1", req_if.req_ready);
        end
        vectors++;
        if (tex_changed !== 1'b0 || frame_tick !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL reset_pulses: got chg=%b tick=%b expected 0/0", tex_changed, frame_tick);
        end
        reset = 1'b0;
        for (int f = 0; f < 2; f++) begin
            mid_frame(4);
            run_boundary((f == 0) ? 1 : 3, t0, c0, k0, nt, nc);
            vectors++;
            if (k0 !== 1'b1 || nt != 1) begin
                miscompares++;
                $display("[TB] FAIL idle_frame_tick: got first=%b count=%0d expected 1/1", k0, nt);
            end
            vectors++;
            if (nc != 0 || t0 !== 2'd0) begin
                miscompares++;
                $display("[TB] FAIL idle_texture: got tex=%0d changes=%0d expected 0/0", t0, nc);
            end
        end
    endtask

    task automatic test_mid_frame_request();
        logic [1:0] t0;
        logic       c0, k0;
        int         nt, nc;
        mid_frame(2);
        req_if.req_valid   = 1'b1;
        req_if.req_texture = 2'd2;
        tick();
        req_if.req_valid = 1'b0;
        vectors++;
        if (req_if.req_ready !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL midreq_ready_drop: got %b expected 0", req_if.req_ready);
        end
        mid_frame(3);
        vectors++;
        if (texture !== 2'd0) begin
            miscompares++;
            $display("[TB] FAIL midreq_hold: got %0d expected 0", texture);
        end
        run_boundary(1, t0, c0, k0, nt, nc);
        vectors++;
        if (t0 !== 2'd2 || c0 !== 1'b1 || nc != 1) begin
            miscompares++;
            $display("[TB] FAIL midreq_commit: got tex=%0d chg=%b n=%0d expected 2/1/1", t0, c0, nc);
        end
        vectors++;
        if (req_if.req_ready !== 1'b1) begin
            miscompares++;
            $display("[TB] FAIL midreq_ready_back: got %b expected 1", req_if.req_ready);
        end
    endtask

    task automatic test_back_to_back();
        logic [1:0] t0;
        logic       c0, k0;
        int         nt, nc;
        mid_frame(2);
        req_if.req_valid   = 1'b1;
        req_if.req_texture = 2'd1;
        tick();
        req_if.req_texture = 2'd3;
        tick();
        tick();
        vectors++;
        if (req_if.req_ready !== 1'b0 || texture !== 2'd2) begin
            miscompares++;
            $display("[TB] FAIL b2b_held_off: got ready=%b tex=%0d expected 0/2", req_if.req_ready, texture);
        end
        DrawX = 10'd0;
        DrawY = 10'd480;
        tick();
        vectors++;
        if (texture !== 2'd1 || tex_changed !== 1'b1 || req_if.req_ready !== 1'b1) begin
            miscompares++;
            $display("[TB] FAIL b2b_first_commit: got tex=%0d chg=%b ready=%b expected 1/1/1",
                     texture, tex_changed, req_if.req_ready);
        end
        DrawX = 10'd1;
        tick();
        req_if.req_valid = 1'b0;
        vectors++;
        if (req_if.req_ready !== 1'b0 || texture !== 2'd1 || tex_changed !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL b2b_second_accept: got ready=%b tex=%0d chg=%b expected 0/1/0",
                     req_if.req_ready, texture, tex_changed);
        end
        mid_frame(3);
        run_boundary(1, t0, c0, k0, nt, nc);
        vectors++;
        if (t0 !== 2'd3 || c0 !== 1'b1) begin
            miscompares++;
            $display("[TB] FAIL b2b_second_commit: got tex=%0d chg=%b expected 3/1", t0, c0);
        end
    endtask

    task automatic test_request_on_boundary();
        logic [1:0] t0;
        logic       c0, k0;
        int         nt, nc;
        mid_frame(2);
        DrawX = 10'd0;
        DrawY = 10'd480;
        req_if.req_valid   = 1'b1;
        req_if.req_texture = 2'd0;
        tick();
        req_if.req_valid = 1'b0;
        vectors++;
        if (texture !== 2'd3 || tex_changed !== 1'b0 || frame_tick !== 1'b1 || req_if.req_ready !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL fbreq_not_applied: got tex=%0d chg=%b tick=%b ready=%b expected 3/0/1/0",
                     texture, tex_changed, frame_tick, req_if.req_ready);
        end
        DrawX = 10'd1;
        tick();
        tick();
        mid_frame(3);
        run_boundary(1, t0, c0, k0, nt, nc);
        vectors++;
        if (t0 !== 2'd0 || c0 !== 1'b1) begin
            miscompares++;
            $display("[TB] FAIL fbreq_next_commit: got tex=%0d chg=%b expected 0/1", t0, c0);
        end
    endtask

    task automatic test_auto_cycle();
        logic [1:0] t0;
        logic       c0, k0;
        int         nt, nc;
        logic [1:0] exp_tex [8] = '{2'd3, 2'd0, 2'd0, 2'd1, 2'd1, 2'd0, 2'd0, 2'd1};
        logic       exp_chg [8] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
        mid_frame(2);
        req_if.req_valid   = 1'b1;
        req_if.req_texture = 2'd3;
        tick();
        req_if.req_valid = 1'b0;
        mid_frame(2);
        run_boundary(1, t0, c0, k0, nt, nc);
        vectors++;
        if (t0 !== 2'd3) begin
            miscompares++;
            $display("[TB] FAIL auto_start: got %0d expected 3", t0);
        end
        auto_en = 1'b1;
        for (int k = 0; k < 8; k++) begin
            mid_frame(2);
            if (k == 5) begin
                req_if.req_valid   = 1'b1;
                req_if.req_texture = 2'd0;
                tick();
                req_if.req_valid = 1'b0;
                vectors++;
                if (req_if.req_ready !== 1'b0) begin
                    miscompares++;
                    $display("[TB] FAIL auto_inject_ready: got %b expected 0", req_if.req_ready);
                end
            end
            run_boundary(1, t0, c0, k0, nt, nc);
            vectors++;
            if (t0 !== exp_tex[k] || c0 !== exp_chg[k]) begin
                miscompares++;
                $display("[TB] FAIL auto_fb%0d: got tex=%0d chg=%b expected %0d/%b",
                         k + 1, t0, c0, exp_tex[k], exp_chg[k]);
            end
        end
        auto_en = 1'b0;
    endtask

    task automatic test_reset_pending();
        logic [1:0] t0;
        logic       c0, k0;
        int         nt, nc;
        mid_frame(2);
        req_if.req_valid   = 1'b1;
        req_if.req_texture = 2'd1;
        tick();
        req_if.req_valid = 1'b0;
        vectors++;
        if (req_if.req_ready !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL rstpend_accepted: got ready=%b expected 0", req_if.req_ready);
        end
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        vectors++;
        if (texture !== 2'd0 || req_if.req_ready !== 1'b1) begin
            miscompares++;
            $display("[TB] FAIL rstpend_state: got tex=%0d ready=%b expected 0/1", texture, req_if.req_ready);
        end
        mid_frame(3);
        run_boundary(1, t0, c0, k0, nt, nc);
        vectors++;
        if (t0 !== 2'd0 || nc != 0 || k0 !== 1'b1) begin
            miscompares++;
            $display("[TB] FAIL rstpend_no_commit: got tex=%0d changes=%0d tick=%b expected 0/0/1", t0, nc, k0);
        end
    endtask

`ifdef TEXTURE_SEL_STEP_EN
    task automatic test_step();
        logic [1:0] t0;
        logic       c0, k0;
        int         nt, nc;
        logic [1:0] exp_tex [2] = '{2'd1, 2'd2};
        for (int k = 0; k < 2; k++) begin
            mid_frame(2);
            step = 1'b1;
            tick();
            step = 1'b0;
            vectors++;
            if (req_if.req_ready !== 1'b0) begin
                miscompares++;
                $display("[TB] FAIL step_queued%0d: got ready=%b expected 0", k, req_if.req_ready);
            end
            mid_frame(2);
            run_boundary(1, t0, c0, k0, nt, nc);
            vectors++;
            if (t0 !== exp_tex[k] || c0 !== 1'b1) begin
                miscompares++;
                $display("[TB] FAIL step_commit%0d: got tex=%0d chg=%b expected %0d/1", k, t0, c0, exp_tex[k]);
            end
        end
        mid_frame(2);
        step               = 1'b1;
        req_if.req_valid   = 1'b1;
        req_if.req_texture = 2'd0;
        tick();
        step             = 1'b0;
        req_if.req_valid = 1'b0;
        mid_frame(2);
        run_boundary(1, t0, c0, k0, nt, nc);
        vectors++;
        if (t0 !== 2'd0) begin
            miscompares++;
            $display("[TB] FAIL step_vs_req: got tex=%0d expected 0", t0);
        end
    endtask
`endif

    initial begin
        reset              = 1'b1;
        DrawX              = 10'd5;
        DrawY              = 10'd100;
        auto_en            = 1'b0;
        req_if.req_valid   = 1'b0;
        req_if.req_texture = 2'd0;
`ifdef TEXTURE_SEL_STEP_EN
        step               = 1'b0;
`endif
        test_reset();
        test_mid_frame_request();
        test_back_to_back();
        test_request_on_boundary();
        test_auto_cycle();
        test_reset_pending();
`ifdef TEXTURE_SEL_STEP_EN
        test_step();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
